// File: rtl/alu_operand_seq.sv
// alu_operand_seq: sequences register-file operands through an external ALU (IDLE->RA->RB->EX->WB)
module alu_operand_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [2:0]  rd,
  input  logic [2:0]  rn,
  input  logic [2:0]  rm,
  input  logic [1:0]  shift,
  input  logic        wb,
  input  logic        ld_en,
  input  logic [2:0]  ld_addr,
  input  logic [15:0] ld_data,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [1:0]  alu_op,
  input  logic [15:0] alu_out,
  input  logic [2:0]  alu_z,
  output logic [15:0] result,
  output logic [2:0]  status,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, RA, RB, EX, WB} state_t;
  state_t state_q, state_d;
  logic [15:0] rf_q [8];
  logic [15:0] a_q, b_q, c_q, rm_val, b_shift;
  logic [2:0]  status_q, rd_q, rn_q, rm_q;
  logic [1:0]  op_q, shift_q;
  logic        wb_q, done_q;
  assign rm_val  = rf_q[rm_q];
  assign b_shift = shift_q == 2'b01 ? {rm_val[14:0], 1'b0} :
                   shift_q == 2'b10 ? {1'b0, rm_val[15:1]} :
                   shift_q == 2'b11 ? {rm_val[15], rm_val[15:1]} : rm_val;
  assign dbg_data = rf_q[dbg_addr];
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_q;
  assign result   = c_q;
  assign status   = status_q;
  assign busy     = state_q != IDLE;
  assign done     = done_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? RA : IDLE;
      RA:      state_d = RB;
      RB:      state_d = EX;
      EX:      state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  // Loads are only honoured in IDLE, so a load can never race the WB write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      shift_q  <= '0;
      wb_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ld_en) rf_q[ld_addr] <= ld_data;
          if (start) begin
            op_q    <= op;
            rd_q    <= rd;
            rn_q    <= rn;
            rm_q    <= rm;
            shift_q <= shift;
            wb_q    <= wb;
          end
        end
        RA: a_q <= rf_q[rn_q];
        RB: b_q <= b_shift;
        EX: begin
          c_q      <= alu_out;
          status_q <= alu_z;
        end
        WB: begin
          if (wb_q) rf_q[rd_q] <= c_q;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/alu_operand_seq.md
ALU_OPERAND_SEQ -- requirements
Module: alu_operand_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-002 The block SHALL provide: reset_n  in  1  asynchronous active-low reset.
REQ-003 The block SHALL provide: start  in  1  request to run one operation; sampled only in IDLE.
REQ-004 The block SHALL provide: op  in  2  ALU operation code (00 add, 01 sub, 10 and, 11 not-B).
REQ-005 The block SHALL provide: rd, rn, rm  in  3 each  destination, A-source and B-source register indices.
REQ-006 The block SHALL provide: shift  in  2  B-operand shift (00 none, 01 LSL1, 10 LSR1 zero-fill, 11 ASR1).
REQ-007 The block SHALL provide: wb  in  1  1 = write result to rd; 0 = flags only.
REQ-008 The block SHALL provide: ld_en  in  1, ld_addr  in  3, ld_data  in  16  external register load.
REQ-009 The block SHALL provide: dbg_addr  in  3, dbg_data  out  16  combinational register-file readout.
REQ-010 The block SHALL provide: alu_a  out  16, alu_b  out  16, alu_op  out  2  operands and op code driven to the ALU.
REQ-011 The block SHALL provide: alu_out  in  16, alu_z  in  3  ALU result and flags {N, V, Z}.
REQ-012 The block SHALL provide: result  out  16 (C register), status  out  3 (flag register), busy  out  1, done  out  1.

Function
REQ-013 The block SHALL contain an 8 x 16-bit register file, A, B and C registers, a 3-bit status register and a 5-state FSM: IDLE, RA, RB, EX, WB.
REQ-014 The FSM in IDLE with start=1 SHALL, at the clock edge, latch op/rd/rn/rm/shift/wb and go to RA; with start=0 it SHALL stay in IDLE.
REQ-015 The RA edge SHALL load A <= R[rn] and go to RB.
REQ-016 The RB edge SHALL load B <= shift(R[rm]) per REQ-006 and go to EX.
REQ-017 The EX edge SHALL load C <= alu_out and status <= alu_z and go to WB.
REQ-018 The WB edge SHALL write R[rd] <= C only if the latched wb=1, SHALL set done, and SHALL go to IDLE.
REQ-019 done SHALL be a registered single-cycle pulse, high exactly in the cycle after the WB edge; the start edge to done rising SHALL take exactly 5 edges.
REQ-020 busy SHALL be 1 whenever state != IDLE and SHALL be combinational from state.
REQ-021 alu_a = A, alu_b = B and alu_op = the latched op SHALL hold at all times.
REQ-022 Shifts SHALL keep 16-bit width: LSL1 drops bit 15, LSR1 inserts 0 at bit 15, ASR1 replicates bit 15.
REQ-023 ld_en=1 in IDLE SHALL write R[ld_addr] <= ld_data at the edge.
REQ-024 ld_en while busy SHALL be ignored, with no register change.
REQ-025 When ld_en and start occur in the same IDLE cycle, both SHALL take effect, and the RA/RB reads SHALL see the loaded value.
REQ-026 start while busy SHALL be ignored.
REQ-027 start in the done cycle, which is IDLE, SHALL be accepted.
REQ-028 Back-to-back dependent operations SHALL read the value written by the previous WB, because the register file is written before the next RA.
REQ-029 An operation with wb=0 SHALL update result and status but SHALL leave the register file unchanged.

Reset
REQ-030 While reset_n is low, the FSM SHALL be forced to IDLE immediately, independent of clk.
REQ-031 While reset_n is low, all R0-R7, A, B, C and the latched fields SHALL be forced to 0, and status SHALL be 3'b000.
REQ-032 While reset_n is low, busy and done SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL abort it: no register-file write and no done pulse.
REQ-034 After reset_n deasserts, the block SHALL accept start on the first clock edge.

Verification
REQ-035 Load R0=5 and R1=3, then start with op=00, rd=2, rn=0, rm=1, shift=00, wb=1 -> done after 5 edges, result=16'd8, R2=8, status=000.
REQ-036 Start with op=01, rn=rm=0 (R0=5), wb=0 -> result=0, status[0]=1, R-file unchanged.
REQ-037 Load R3=16'h8004, then start with op=11, rm=3, shift=11 -> alu_b=16'hC002, result=16'h3FFD, status[2]=0.
REQ-038 Hold start=1 continuously -> operations complete every 5 cycles; starts asserted while busy are not counted; done pulses once per operation.
REQ-039 Assert reset_n=0 while in EX -> busy=0 and all registers=0 immediately; no done pulse; next start runs normally.
REQ-040 In the same IDLE cycle, assert ld_en (R4=7) and start with op=00, rd=5, rn=4, rm=4 -> R5=16'd14.
